// File: rtl/tt_bist_harness.sv
// tt_bist_harness: pattern-driven BIST for a user design; MISR-compresses the
// responses and compares the signature against a golden value.
module tt_bist_harness #(
    parameter int               WIDTH     = 8,
    parameter int               N_CYCLES  = 256,
    parameter int               LATENCY   = 0,
    parameter logic [WIDTH-1:0] LFSR_POLY = WIDTH'('hB8),
    parameter logic [WIDTH-1:0] LFSR_SEED = WIDTH'('h01),
    parameter logic [WIDTH-1:0] MISR_POLY = WIDTH'('hB8)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] const_in,
    input  logic [WIDTH-1:0] golden_sig,
    output logic [WIDTH-1:0] stim_out,
    input  logic [WIDTH-1:0] resp_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature
);
    localparam int TOT = N_CYCLES + LATENCY;
    localparam int CW = $clog2(TOT + 1);
    localparam logic [CW-1:0] LAST = CW'(TOT - 1);
    localparam logic [CW-1:0] LAT = CW'(LATENCY);
    localparam logic [CW-1:0] NLAST = CW'(N_CYCLES - 1);
    localparam logic [WIDTH-1:0] SEED = (LFSR_SEED == '0) ? WIDTH'(1) : LFSR_SEED;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [1:0]       mode_l;
    logic [WIDTH-1:0] const_l;
    logic [WIDTH-1:0] sig_nx;
    logic [WIDTH-1:0] pat_nx;
    logic [WIDTH-1:0] pat0;

    // The next pattern is derived from the current stimulus, so no separate pattern register is needed
    always_comb begin
        sig_nx = {signature[WIDTH-2:0], ^(signature & MISR_POLY)} ^ resp_in;
        pat_nx = (mode_l == 2'd0) ? stim_out + WIDTH'(1) :
                 (mode_l == 2'd1) ? {stim_out[WIDTH-2:0], ^(stim_out & LFSR_POLY)} :
                 (mode_l == 2'd2) ? {stim_out[WIDTH-2:0], stim_out[WIDTH-1]} : const_l;
        pat0   = (mode == 2'd0) ? '0 : (mode == 2'd1) ? SEED :
                 (mode == 2'd2) ? WIDTH'(1) : const_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mode_l    <= '0;
            const_l   <= '0;
            stim_out  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            signature <= '0;
        end else if (state != RUN) begin
            if (start) begin
                state     <= RUN;
                cnt       <= '0;
                mode_l    <= mode;
                const_l   <= const_in;
                stim_out  <= pat0;
                busy      <= 1'b1;
                done      <= 1'b0;
                pass      <= 1'b0;
                signature <= '0;
            end
        end else if (abort) begin
            state    <= IDLE;
            cnt      <= '0;
            stim_out <= '0;
            busy     <= 1'b0;
        end else begin
            if (cnt >= LAT)
                signature <= sig_nx;
            cnt      <= cnt + CW'(1);
            stim_out <= (cnt < NLAST) ? pat_nx : '0;
            // The final cycle always captures, so the golden compare uses the updated signature
            if (cnt == LAST) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= (sig_nx == golden_sig);
            end
        end
    end
endmodule

// File: tb/tb_tt_bist_harness.sv
// tb_tt_bist_harness: directed checks of the BIST harness in three configurations
// (N=4 loopback, N=10 loopback, N=4 with a 2-stage delayed loopback).
module tb_tt_bist_harness;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode = 2'd0;
    logic [7:0] cin = 8'h00;
    logic       start [3];
    logic       abort [3];
    logic [7:0] gold [3];
    logic [7:0] stim [3];
    logic [7:0] resp [3];
    logic       busy [3];
    logic       done [3];
    logic       pass [3];
    logic [7:0] sig [3];
    logic [7:0] d1, d2;
    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] expq [$];
    logic [7:0] sigq [$];

    always #5 clk = ~clk;

    assign resp[0] = stim[0];
    assign resp[1] = stim[1];
    assign resp[2] = d2;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            d1 <= 8'h00;
            d2 <= 8'h00;
        end else begin
            d1 <= stim[2];
            d2 <= d1;
        end

    tt_bist_harness #(.WIDTH(8), .N_CYCLES(4), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]), .mode(mode), .const_in(cin),
        .golden_sig(gold[0]), .stim_out(stim[0]), .resp_in(resp[0]), .busy(busy[0]),
        .done(done[0]), .pass(pass[0]), .signature(sig[0]));

    tt_bist_harness #(.WIDTH(8), .N_CYCLES(10), .LATENCY(0)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]), .mode(mode), .const_in(cin),
        .golden_sig(gold[1]), .stim_out(stim[1]), .resp_in(resp[1]), .busy(busy[1]),
        .done(done[1]), .pass(pass[1]), .signature(sig[1]));

    tt_bist_harness #(.WIDTH(8), .N_CYCLES(4), .LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .start(start[2]), .abort(abort[2]), .mode(mode), .const_in(cin),
        .golden_sig(gold[2]), .stim_out(stim[2]), .resp_in(resp[2]), .busy(busy[2]),
        .done(done[2]), .pass(pass[2]), .signature(sig[2]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int m, input int i, input logic [7:0] c);
        logic [7:0] s;
        s = 8'h01;
        for (int k = 0; k < i; k++) s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        return (m == 0) ? 8'(i % 256) : (m == 1) ? s : (m == 2) ? 8'(1 << (i % 8)) : c;
    endfunction

    task automatic run(input int d, input int m, input logic [7:0] c, input logic [7:0] g,
                       input int n, input int lat);
        logic [7:0] sg;
        logic [7:0] e;
        sg = 8'h00;
        mode = 2'(m);
        cin = c;
        gold[d] = g;
        start[d] = 1'b1;
        for (int i = 0; i < n; i++) begin
            expq.push_back(pat(m, i, c));
            sg = {sg[6:0], sg[7] ^ sg[5] ^ sg[4] ^ sg[3]} ^ pat(m, i, c);
        end
        for (int i = 0; i < lat; i++) expq.push_back(8'h00);
        sigq.push_back(sg);
        tick();
        start[d] = 1'b0;
        for (int k = 0; k < n + lat; k++) begin
            chk($sformatf("d%0d_busy_%0d", d, k), 32'(busy[d]), 32'd1);
            chk($sformatf("d%0d_m%0d_stim_%0d", d, m, k), 32'(stim[d]), 32'(expq.pop_front()));
            tick();
        end
        e = sigq.pop_front();
        chk($sformatf("d%0d_done", d), 32'(done[d]), 32'd1);
        chk($sformatf("d%0d_busy_end", d), 32'(busy[d]), 32'd0);
        chk($sformatf("d%0d_stim_end", d), 32'(stim[d]), 32'd0);
        chk($sformatf("d%0d_sig", d), 32'(sig[d]), 32'(e));
        chk($sformatf("d%0d_pass", d), 32'(pass[d]), 32'(e == g));
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            abort[i] = 1'b0;
            gold[i] = 8'h00;
        end
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'd0);
            chk($sformatf("rst_done%0d", i), 32'(done[i]), 32'd0);
            chk($sformatf("rst_stim%0d", i), 32'(stim[i]), 32'd0);
            chk($sformatf("rst_sig%0d", i), 32'(sig[i]), 32'd0);
        end
        rst = 1'b0;
        tick();
        chk("idle_no_start", 32'(busy[0]), 32'd0);

        run(0, 0, 8'h00, 8'h03, 4, 0);
        chk("counter_sig_03", 32'(sig[0]), 32'h03);
        run(1, 1, 8'h00, 8'h00, 10, 0);
        run(1, 2, 8'h00, 8'h00, 10, 0);
        run(2, 0, 8'h00, 8'h03, 4, 2);
        chk("lat2_sig_03", 32'(sig[2]), 32'h03);
        chk("lat2_pass", 32'(pass[2]), 32'd1);
        run(0, 3, 8'h5A, 8'h00, 4, 0);
        run(0, 3, 8'hC3, 8'hD3, 4, 0);

        // abort in RUN cycle 1
        mode = 2'd0;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        chk("abort_c0_stim", 32'(stim[0]), 32'h00);
        tick();
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        chk("abort_busy", 32'(busy[0]), 32'd0);
        chk("abort_done", 32'(done[0]), 32'd0);
        chk("abort_stim", 32'(stim[0]), 32'd0);
        tick();
        chk("abort_stays_idle", 32'(busy[0]), 32'd0);
        run(0, 0, 8'h00, 8'h03, 4, 0);

        // start while busy is ignored, then reset mid-run
        mode = 2'd0;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        tick();
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        chk("start_ignored_stim", 32'(stim[0]), 32'h02);
        chk("start_ignored_busy", 32'(busy[0]), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy[0]), 32'd0);
        chk("midrst_stim", 32'(stim[0]), 32'd0);
        chk("midrst_sig", 32'(sig[0]), 32'd0);
        chk("midrst_done", 32'(done[0]), 32'd0);
        chk("midrst_pass_prev", 32'(pass[1]), 32'd0);
        rst = 1'b0;
        tick();
        run(0, 0, 8'h00, 8'h00, 4, 0);
        chk("golden_mismatch_pass", 32'(pass[0]), 32'd0);
        tick();
        tick();
        chk("done_held", 32'(done[0]), 32'd1);
        chk("sig_held", 32'(sig[0]), 32'h03);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
